// File: rtl/core_hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline, stall/flush/redirect back to it.
// The controller is the slave side; the pipeline (or a bench) is the master.
interface core_hazard_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              jump_en_ex;
  logic [XLEN-1:0]   jump_addr_ex;
  logic              mem_read_ex;
  logic [REG_AW-1:0] rd_ex;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic              rs1_used_id;
  logic              rs2_used_id;
  logic              md_start_ex;
  logic              md_done;
  logic              dmem_req_mem;
  logic              dmem_ack_mem;

  logic              jump;
  logic [XLEN-1:0]   jump_addr;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              stall_mem;
  logic              flush_id;
  logic              flush_ex;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output jump_en_ex, jump_addr_ex, mem_read_ex, rd_ex, rs1_id, rs2_id,
           rs1_used_id, rs2_used_id, md_start_ex, md_done, dmem_req_mem, dmem_ack_mem,
    input  jump, jump_addr, stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, mem_err, stall_cycles
  );

  modport slave (
    input  jump_en_ex, jump_addr_ex, mem_read_ex, rd_ex, rs1_id, rs2_id,
           rs1_used_id, rs2_used_id, md_start_ex, md_done, dmem_req_mem, dmem_ack_mem,
    output jump, jump_addr, stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, mem_err, stall_cycles
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges jump, load-use, MUL/DIV and
// data-memory hazards into per-stage stall/flush and a PC redirect.
module core_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_sync,
  core_hazard_ctrl_if.slave   hz
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic mem_hold;
  logic load_use;
  logic rs1_hit, rs2_hit;

  logic            jump_c;
  logic            stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
  logic            flush_id_c, flush_ex_c;
  logic            mem_err_c;

  assign mem_hold = hz.dmem_req_mem & ~hz.dmem_ack_mem;
  assign rs1_hit  = hz.rs1_used_id & (hz.rs1_id == hz.rd_ex);
  assign rs2_hit  = hz.rs2_used_id & (hz.rs2_id == hz.rd_ex);
  assign load_use = hz.mem_read_ex & (hz.rd_ex != '0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_if_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    jump_c       = 1'b0;
    stall_if_c   = 1'b0;
    stall_id_c   = 1'b0;
    stall_ex_c   = 1'b0;
    stall_mem_c  = 1'b0;
    flush_id_c   = 1'b0;
    flush_ex_c   = 1'b0;
    mem_err_c    = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_hold) begin
          // EX is frozen behind MEM, so its jump/MD/load-use are re-evaluated on release
          stall_if_c   = 1'b1;
          stall_id_c   = 1'b1;
          stall_ex_c   = 1'b1;
          stall_mem_c  = 1'b1;
          wait_cnt_nxt = WCW'(1);
          state_nxt    = MEM_WAIT;
        end else if (hz.md_start_ex && !hz.md_done) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
          state_nxt  = MD_WAIT;
        end else if (hz.jump_en_ex) begin
          jump_c     = 1'b1;
          flush_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end else if (load_use) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end
      end

      MD_WAIT: begin
        if (hz.md_done) begin
          state_nxt = RUN;
        end else begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (hz.dmem_ack_mem) begin
          wait_cnt_nxt = '0;
          state_nxt    = RUN;
        end else if (wait_cnt >= WCW'(MEM_TIMEOUT)) begin
          // timed out: MEM retires as faulted and the pipeline moves on
          mem_err_c    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = RUN;
        end else begin
          stall_if_c   = 1'b1;
          stall_id_c   = 1'b1;
          stall_ex_c   = 1'b1;
          stall_mem_c  = 1'b1;
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end

      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign hz.jump         = jump_c      & ~rst_sync;
  assign hz.jump_addr    = (jump_c & ~rst_sync) ? hz.jump_addr_ex : '0;
  assign hz.stall_if     = stall_if_c  & ~rst_sync;
  assign hz.stall_id     = stall_id_c  & ~rst_sync;
  assign hz.stall_ex     = stall_ex_c  & ~rst_sync;
  assign hz.stall_mem    = stall_mem_c & ~rst_sync;
  assign hz.flush_id     = flush_id_c  & ~rst_sync;
  assign hz.flush_ex     = flush_ex_c  & ~rst_sync;
  assign hz.mem_err      = mem_err_c   & ~rst_sync;
  assign hz.stall_cycles = stall_cnt;

endmodule
